draw_scheduler: RTL

Shares the single `vga_adapter` plot port among up to `NUM_REQ` drawing clients. Each client posts a rectangle command: origin, size, colour, fill/outline. The block arbitrates round-robin, rasterises the winning rectangle one pixel per clock onto `x`/`y`/`colour`/`plot`, and clips anything outside the 160x120 frame. It sits between game-logic blocks (cursor, tumbler sprites, score boxes) and the VGA adapter, replacing ad-hoc per-client plot muxing.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/rect_raster.sv | 117 +++++++++++
 rtl/draw_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared frame geometry, pixel widths, FSM state type and colour constants for
// the blocks that drive the VGA adapter plot port.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;
  localparam int XS_W     = X_W + 1;
  localparam int YS_W     = Y_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] RED   = 3'b100;

  function automatic logic in_frame(input logic [XS_W-1:0] sx, input logic [YS_W-1:0] sy);
    return (sx < XS_W'(SCREEN_W)) && (sy < YS_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rect_raster.sv
// Walks one latched rectangle row-major, one position per clock, and registers
// the pixel (position, colour, edge/clip-qualified plot) for the adapter.
module rect_raster
  import vga_pkg::*;
#(
  parameter int SZ_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   start_x,
  input  logic [Y_W-1:0]   start_y,
  input  logic [SZ_W-1:0]  start_w,
  input  logic [SZ_W-1:0]  start_h,
  input  logic [COL_W-1:0] start_colour,
  input  logic             start_fill,
  output logic             last,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  logic             active_q, active_d;
  logic [X_W-1:0]   ox_q, ox_d;
  logic [Y_W-1:0]   oy_q, oy_d;
  logic [SZ_W-1:0]  w_q, w_d, h_q, h_d, cx_q, cx_d, cy_q, cy_d;
  logic [COL_W-1:0] col_q, col_d, colour_q, colour_d;
  logic             fill_q, fill_d, plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [XS_W-1:0]  sum_x_s;
  logic [YS_W-1:0]  sum_y_s;
  logic             visible_s;

  // cx/cy name the position on the outputs now; the pixel registered here is
  // the one for the position that will be current next cycle.
  always_comb begin
    active_d = active_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    fill_d   = fill_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    last     = active_q && (cx_q == w_q) && (cy_q == h_q);
    if (start) begin
      active_d = 1'b1;
      ox_d     = start_x;
      oy_d     = start_y;
      w_d      = start_w;
      h_d      = start_h;
      col_d    = start_colour;
      fill_d   = start_fill;
      cx_d     = '0;
      cy_d     = '0;
    end else if (last) begin
      active_d = 1'b0;
      cx_d     = '0;
      cy_d     = '0;
    end else if (active_q && (cx_q == w_q)) begin
      cx_d = '0;
      cy_d = cy_q + SZ_W'(1);
    end else if (active_q) begin
      cx_d = cx_q + SZ_W'(1);
    end else begin
      active_d = 1'b0;
    end
    sum_x_s   = XS_W'(ox_d) + XS_W'(cx_d);
    sum_y_s   = YS_W'(oy_d) + YS_W'(cy_d);
    visible_s = fill_d || (cx_d == '0) || (cx_d == w_d) || (cy_d == '0) || (cy_d == h_d);
    x_d       = active_d ? sum_x_s[X_W-1:0] : '0;
    y_d       = active_d ? sum_y_s[Y_W-1:0] : '0;
    colour_d  = active_d ? col_d : BLACK;
    plot_d    = active_d && visible_s && in_frame(sum_x_s, sum_y_s);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      fill_q   <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      fill_q   <= fill_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin arbiter that hands the single VGA plot port to one rectangle
// client at a time and lets rect_raster draw its command.
module draw_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SZ_W    = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int IDX_W  = ID_W + 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*8-1:0]    req_x,
  input  logic [NUM_REQ*7-1:0]    req_y,
  input  logic [NUM_REQ*SZ_W-1:0] req_w,
  input  logic [NUM_REQ*SZ_W-1:0] req_h,
  input  logic [NUM_REQ*3-1:0]    req_colour,
  input  logic [NUM_REQ-1:0]      req_fill,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COL_W-1:0]        colour,
  output logic                    plot,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, winner_s;
  logic              busy_q, busy_d;
  logic              found_s, handshake_s, raster_last_s;
  logic [IDX_W-1:0]  idx_sum_s;
  logic [ID_W-1:0]   idx_s;

  // First valid client at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s   = 1'b0;
    winner_s  = '0;
    idx_sum_s = '0;
    idx_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum_s = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (idx_sum_s >= IDX_W'(NUM_REQ)) begin
        idx_sum_s = idx_sum_s - IDX_W'(NUM_REQ);
      end else begin
        idx_sum_s = idx_sum_s;
      end
      idx_s = idx_sum_s[ID_W-1:0];
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign handshake_s = resetn && (state_q == IDLE) && found_s;
  assign req_ready   = handshake_s ? (NUM_REQ'(1) << winner_s) : '0;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (handshake_s) begin
          state_d    = DRAW;
          rr_ptr_d   = (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : winner_s + ID_W'(1);
          grant_id_d = winner_s;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (raster_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAW;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  rect_raster #(.SZ_W(SZ_W)) u_raster (
    .clock        (clock),
    .resetn       (resetn),
    .start        (handshake_s),
    .start_x      (req_x[int'(winner_s)*X_W +: X_W]),
    .start_y      (req_y[int'(winner_s)*Y_W +: Y_W]),
    .start_w      (req_w[int'(winner_s)*SZ_W +: SZ_W]),
    .start_h      (req_h[int'(winner_s)*SZ_W +: SZ_W]),
    .start_colour (req_colour[int'(winner_s)*COL_W +: COL_W]),
    .start_fill   (req_fill[winner_s]),
    .last         (raster_last_s),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot)
  );

  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule
